keypad_event: RTL

Upstream input stage for the tic-tac-toe board: drives the 3-column keypad scan, synchronises and debounces the 4 row lines, and turns each debounced physical press into exactly one single-cycle `key_valid` pulse with a decoded `key_code`. It feeds the board/turn logic, which consumes one event per press and never sees bounce, repeats while held, or multi-key chords.

---
 rtl/keypad_event.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_event.sv
`default_nettype none
// ---------------------------------------------------------------------------
// keypad_event : 3x4 keypad scanner with row synchroniser, frame decode and
//                press/release debounce producing one event per press.
// Revision     : 1.0
// ---------------------------------------------------------------------------
module keypad_event #(
   parameter int SCAN_DIV = 12500,
   parameter int DEBOUNCE = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] key_row,
   output logic [2:0] key_col,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic       key_held
);

   localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [3:0]      DEB_N    = 4'(DEBOUNCE);
   localparam logic [3:0]      CODE_NONE  = 4'd0;
   localparam logic [3:0]      CODE_AMBIG = 4'd15;

   typedef enum logic [2:0] {
      COL_IDLE = 3'b000,
      COL_1    = 3'b001,
      COL_2    = 3'b010,
      COL_3    = 3'b100
   } col_e;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } deb_e;

   logic [3:0]       sync1_q, sync2_q;
   logic [DIV_W-1:0] div_q, div_d;
   logic             tick;
   col_e             col_q, col_d;
   logic [3:0]       acc_q, acc_d;
   logic [1:0]       col_idx;
   logic [3:0]       sampled;
   logic             frame_done;
   logic [3:0]       frame_code;
   deb_e             state_q, state_d;
   logic [3:0]       cand_q, cand_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [3:0]       cnt_inc;
   logic             frame_is_key;
   logic             valid_q, valid_d;
   logic [3:0]       code_q, code_d;
   logic             held_q, held_d;

   // Folds one column's rows into the running frame code: any second key,
   // or more than one row in a column, makes the frame ambiguous.
   function automatic logic [3:0] merge_col(input logic [3:0] acc,
                                            input logic [3:0] rows,
                                            input logic [1:0] cidx);
      logic [3:0] base;
      logic       onehot;
      base   = 4'd0;
      onehot = 1'b1;
      case (rows)
         4'b0001: base = 4'd0;
         4'b0010: base = 4'd3;
         4'b0100: base = 4'd6;
         4'b1000: base = 4'd9;
         default: onehot = 1'b0;
      endcase
      if (rows == 4'd0) begin
         merge_col = acc;
      end else if ((acc != CODE_NONE) || !onehot) begin
         merge_col = CODE_AMBIG;
      end else begin
         merge_col = base + {2'b00, cidx};
      end
   endfunction

   assign tick = (div_q == DIV_LAST);

   always_comb begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
   end

   // Column scan and frame accumulation
   always_comb begin
      col_d      = col_q;
      acc_d      = acc_q;
      frame_done = 1'b0;
      col_idx    = 2'd0;
      case (col_q)
         COL_1:   col_idx = 2'd1;
         COL_2:   col_idx = 2'd2;
         COL_3:   col_idx = 2'd3;
         default: col_idx = 2'd0;
      endcase
      sampled    = merge_col(acc_q, sync2_q, col_idx);
      frame_code = sampled;
      if (tick) begin
         case (col_q)
            COL_IDLE: col_d = COL_1;
            COL_1: begin
               col_d = COL_2;
               acc_d = sampled;
            end
            COL_2: begin
               col_d = COL_3;
               acc_d = sampled;
            end
            COL_3: begin
               col_d      = COL_1;
               acc_d      = CODE_NONE;
               frame_done = 1'b1;
            end
            default: begin
               col_d = COL_IDLE;
               acc_d = CODE_NONE;
            end
         endcase
      end
   end

   // Debounce state machine, evaluated once per closed frame
   always_comb begin
      state_d      = state_q;
      cand_d       = cand_q;
      cnt_d        = cnt_q;
      valid_d      = 1'b0;
      code_d       = code_q;
      cnt_inc      = (cnt_q == 4'd15) ? 4'd15 : cnt_q + 4'd1;
      frame_is_key = (frame_code != CODE_NONE) && (frame_code <= 4'd12);
      if (frame_done) begin
         case (state_q)
            RELEASED: begin
               if (frame_is_key) begin
                  cand_d = frame_code;
                  cnt_d  = 4'd1;
                  if (DEB_N <= 4'd1) begin
                     code_d  = frame_code;
                     valid_d = 1'b1;
                     state_d = PRESSED;
                  end else begin
                     state_d = PRESS_WAIT;
                  end
               end
            end
            PRESS_WAIT: begin
               if (frame_code == cand_q) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc >= DEB_N) begin
                     code_d  = cand_q;
                     valid_d = 1'b1;
                     state_d = PRESSED;
                  end
               end else if (frame_is_key) begin
                  cand_d = frame_code;
                  cnt_d  = 4'd1;
               end else begin
                  state_d = RELEASED;
               end
            end
            PRESSED: begin
               if (frame_code == CODE_NONE) begin
                  cnt_d   = 4'd1;
                  state_d = (DEB_N <= 4'd1) ? RELEASED : RELEASE_WAIT;
               end
            end
            RELEASE_WAIT: begin
               if (frame_code == CODE_NONE) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc >= DEB_N) begin
                     state_d = RELEASED;
                  end
               end else begin
                  state_d = PRESSED;
               end
            end
            default: state_d = RELEASED;
         endcase
      end
      held_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         div_q   <= '0;
         col_q   <= COL_IDLE;
         acc_q   <= CODE_NONE;
         state_q <= RELEASED;
         cand_q  <= 4'd0;
         cnt_q   <= 4'd0;
         valid_q <= 1'b0;
         code_q  <= 4'd0;
         held_q  <= 1'b0;
      end else begin
         sync1_q <= key_row;
         sync2_q <= sync1_q;
         div_q   <= div_d;
         col_q   <= col_d;
         acc_q   <= acc_d;
         state_q <= state_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         code_q  <= code_d;
         held_q  <= held_d;
      end
   end

   assign key_col   = col_q;
   assign key_valid = valid_q;
   assign key_code  = code_q;
   assign key_held  = held_q;

endmodule
`default_nettype wire
